// File: rtl/ad7352_pkg.sv
// ad7352_pkg: frame slot map, FSM states and the sample record shared by the AD7352 reader and its consumers.
package ad7352_pkg;
    localparam int FRAME_LEN      = 16;
    localparam int LEAD_SLOT      = 0;
    localparam int FIRST_BIT_SLOT = 1;
    localparam int LAST_BIT_SLOT  = 12;
    localparam int LOAD_SLOT      = 13;
    localparam int ADC_BITS       = 12;

    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

    typedef struct packed {
        logic [ADC_BITS-1:0] vcap;
        logic [ADC_BITS-1:0] icap;
        logic [ADC_BITS-1:0] vout;
        logic [ADC_BITS-1:0] iout;
    } adc_sample_t;
endpackage

// File: rtl/ad7352_lane.sv
// ad7352_lane: one serial data lane; MSB-first shift register plus leading-zero check.
module ad7352_lane
    import ad7352_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_shift,
    input  logic                i_check,
    input  logic                i_bit,
    output logic [ADC_BITS-1:0] o_word,
    output logic                o_lead_err
);
    logic [ADC_BITS-1:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_word <= '0;
        else if (i_shift)
            r_word <= {r_word[ADC_BITS-2:0], i_bit};
    end

    assign o_word     = r_word;
    assign o_lead_err = i_check & i_bit;
endmodule

// File: rtl/ad7352_reader.sv
// ad7352_reader: chip-select framing and 4-lane deserialiser for the dual AD7352 pair.
// The ADC serial clock is clk itself; each slot is sampled on the rising edge that ends it.
module ad7352_reader
    import ad7352_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 24,
    parameter int QUIET_MIN     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic                ad_cs,
    input  logic [1:0]          ad_sdata_a,
    input  logic [1:0]          ad_sdata_b,
    output logic                valid,
    output logic [ADC_BITS-1:0] vcap,
    output logic [ADC_BITS-1:0] icap,
    output logic [ADC_BITS-1:0] vout,
    output logic [ADC_BITS-1:0] iout,
    output logic                frame_err,
    output logic                busy
);
    localparam int SP = (SAMPLE_PERIOD < FRAME_LEN + 1) ? FRAME_LEN + 1 : SAMPLE_PERIOD;
    localparam int TW = $clog2(SP);

    state_t                      r_state, w_next;
    logic [3:0]                  r_cnt;
    logic [TW-1:0]               r_timer;
    logic                        r_valid, r_frame_err;
    adc_sample_t                 r_sample;
    logic                        w_conv, w_expired, w_quiet_done, w_start;
    logic                        w_lead, w_shift, w_load;
    logic [3:0]                  w_lanes, w_lead_err;
    logic [3:0][ADC_BITS-1:0]    w_words;

    assign w_conv       = r_state == CONV;
    assign w_expired    = r_timer == '0;
    assign w_quiet_done = ({1'b0, r_cnt} + 5'd1) >= 5'(QUIET_MIN);
    assign w_start      = (w_next == CONV) && !w_conv;
    assign w_lead       = w_conv && r_cnt == 4'(LEAD_SLOT);
    assign w_shift      = w_conv && r_cnt >= 4'(FIRST_BIT_SLOT) && r_cnt <= 4'(LAST_BIT_SLOT);
    assign w_load       = w_conv && r_cnt == 4'(LOAD_SLOT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (enable && w_expired) w_next = CONV;
            CONV:    if (r_cnt == 4'(FRAME_LEN - 1)) w_next = QUIET;
            QUIET:   if (w_quiet_done && w_expired) w_next = enable ? CONV : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Timer reloads on each chip-select fall and saturates at zero, so expiry holds until the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= (w_next != r_state) ? '0 : (r_cnt == '1 ? r_cnt : r_cnt + 4'd1);
            r_timer     <= w_start ? TW'(SP - 1) : (w_expired ? r_timer : r_timer - TW'(1));
            r_valid     <= w_load;
            r_frame_err <= r_frame_err | (|w_lead_err);
            if (w_load)
                r_sample <= adc_sample_t'(w_words);
        end
    end

    // Lane index order {vcap, icap, vout, iout} matches the packed sample layout.
    assign w_lanes = {ad_sdata_b, ad_sdata_a};

    for (genvar g = 0; g < 4; g++) begin : g_lane
        ad7352_lane u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_shift    (w_shift),
            .i_check    (w_lead),
            .i_bit      (w_lanes[g]),
            .o_word     (w_words[g]),
            .o_lead_err (w_lead_err[g])
        );
    end

    assign ad_cs     = !w_conv;
    assign busy      = w_conv;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign vcap      = r_sample.vcap;
    assign icap      = r_sample.icap;
    assign vout      = r_sample.vout;
    assign iout      = r_sample.iout;
endmodule

// File: tb/tb_ad7352_reader.sv
// tb_ad7352_reader: ADC pin model plus scoreboard; each frame the model serialises is queued and checked at valid.
module tb_ad7352_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a, ad_sdata_b;
    logic        valid, frame_err, busy;
    logic [11:0] vcap, icap, vout, iout;

    ad7352_reader dut (
        .clk(clk), .reset(reset), .enable(enable), .ad_cs(ad_cs),
        .ad_sdata_a(ad_sdata_a), .ad_sdata_b(ad_sdata_b), .valid(valid),
        .vcap(vcap), .icap(icap), .vout(vout), .iout(iout),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC model: words indexed 3=vcap 2=icap 1=vout 0=iout
    logic [11:0] nxt[4];
    logic [11:0] cur[4];
    logic [3:0]  lead_inj = 4'b0;
    logic [3:0]  lead;
    logic        rand_mode = 1'b0;
    logic        exp_ferr = 1'b0;
    logic [47:0] exp_q[$];
    int          slot = 0;

    always @(negedge clk) begin
        logic [3:0] b;
        if (ad_cs) begin
            slot = 0;
            ad_sdata_a = 'x;
            ad_sdata_b = 'x;
        end else begin
            if (slot == 0) begin
                for (int l = 0; l < 4; l++) cur[l] = rand_mode ? 12'($urandom) : nxt[l];
                exp_q.push_back({cur[3], cur[2], cur[1], cur[0]});
                lead = lead_inj;
                if (|lead_inj) exp_ferr = 1'b1;
                lead_inj = 4'b0;
            end
            for (int l = 0; l < 4; l++)
                b[l] = (slot == 0) ? lead[l] : (slot <= 12 ? cur[l][12 - slot] : 1'b0);
            ad_sdata_b = b[3:2];
            ad_sdata_a = b[1:0];
            slot++;
        end
    end

    // Monitor
    int cyc = 0, t_fall = 0, nvalid = 0, low_len = 0;
    logic prev_cs = 1'b1;
    int falls[$];

    always @(posedge clk) begin
        logic [47:0] e;
        #1;
        cyc++;
        if (prev_cs && !ad_cs) begin
            t_fall = cyc;
            falls.push_back(cyc);
        end
        if (!ad_cs) low_len++;
        else begin
            if (!prev_cs && reset) chk("cs_low_len", low_len, 16);
            low_len = 0;
        end
        prev_cs = ad_cs;
        if (valid) begin
            nvalid++;
            chk("valid_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("vcap", vcap, e[47:36]);
                chk("icap", icap, e[35:24]);
                chk("vout", vout, e[23:12]);
                chk("iout", iout, e[11:0]);
                chk("frame_err", frame_err, exp_ferr);
                chk("valid_latency", cyc - t_fall, 14);
                chk("busy_at_valid", busy, 1);
            end
        end
    end

    task automatic wait_valids(input int n);
        int seen = nvalid;
        int t = 0;
        while (nvalid < seen + n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #2;
        chk("valid_arrived", nvalid >= seen + n, 1);
    endtask

    task automatic wait_cs_fall();
        int t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while (ad_cs && t < 200);
        chk("cs_fell", ad_cs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        #1;
        chk("rst_cs", ad_cs, 1);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_words", {vcap, icap, vout, iout}, 48'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // basic frame
        nxt[3] = 12'hA00; nxt[2] = 12'h200; nxt[1] = 12'h0A0; nxt[0] = 12'h200;
        enable = 1'b1;
        wait_valids(1);

        // bit order / lane map
        nxt[3] = 12'h800; nxt[2] = 12'h001; nxt[1] = 12'hFFF; nxt[0] = 12'h555;
        wait_valids(1);

        // pacing with random words
        rand_mode = 1'b1;
        falls.delete();
        wait_valids(5);
        chk("pace_falls", falls.size() >= 5, 1);
        for (int i = 1; i < 5 && i < falls.size(); i++) chk("pace_period", falls[i] - falls[i-1], 24);

        // enable dropped at cnt=5
        wait_cs_fall();
        repeat (5) @(posedge clk);
        #2;
        enable = 1'b0;
        wait_valids(1);
        low = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (!ad_cs) low++;
        end
        chk("cs_idle_after_drop", low, 0);

        // reset at cnt=8
        enable = 1'b1;
        wait_cs_fall();
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_cs", ad_cs, 1);
        chk("midrst_words", {vcap, icap, vout, iout}, 48'h0);
        chk("midrst_valid", valid, 0);
        exp_q.delete();
        low = nvalid;
        repeat (4) @(negedge clk);
        chk("midrst_no_valid", nvalid, low);
        reset = 1'b1;
        wait_valids(1);

        // framing error on vout leading slot, then clean frames
        lead_inj = 4'b0010;
        wait_valids(3);
        chk("ferr_sticky", frame_err, 1);

        enable = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("final_rst_ferr", frame_err, 0);
        chk("final_rst_cs", ad_cs, 1);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ad7352_reader.md
Name: ad7352_reader

Overview:
- FPGA-side reader for the dual AD7352 ADC pair, which drives 4 serial lanes on a shared chip select.
- Generates the active-low chip-select frame and samples the 4 serial data lanes on clk rising edges; the ADC serial clock is clk itself, and the ADC drives data on falling edges.
- Deserialises 4 x 12-bit words per frame (vcap, icap, vout, iout) and presents them with a one-cycle valid pulse.
- Sits between the ADC pins and the blaster control loop / ohm_div.

Parameters:
- SAMPLE_PERIOD, 24, clk cycles between successive ad_cs falling edges. Legal minimum is FRAME_LEN+1 (17); smaller values are clamped to 17.
- QUIET_MIN, 1, minimum cycles ad_cs is held high between frames. Legal range 1..8.

Ports:
- clk  in  1  system clock; also serves as the ADC serial clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  continuous conversion enable.
- ad_cs  out  1  ADC chip select, active low.
- ad_sdata_a  in  2  bit1 = vout lane, bit0 = iout lane.
- ad_sdata_b  in  2  bit1 = vcap lane, bit0 = icap lane.
- valid  out  1  one-cycle pulse; word outputs are updated on the same edge that raises it.
- vcap  out  12  capacitor voltage code.
- icap  out  12  capacitor current code.
- vout  out  12  output voltage code.
- iout  out  12  output current code.
- frame_err  out  1  sticky flag: a leading-zero slot sampled nonzero on any lane. Cleared only by reset.
- busy  out  1  high while in the CONV state.

Behaviour:
- Reset (asynchronous, reset=0):
  - ad_cs=1, valid=0, busy=0, frame_err=0.
  - All words = 0, FSM in IDLE, period timer = 0.
  - Asserting reset mid-frame forces ad_cs high immediately; the partial frame is discarded and valid is never produced for it.
- FSM states: IDLE, CONV, QUIET.
- IDLE:
  - ad_cs=1.
  - Moves to CONV on the edge where enable=1 and the period timer has expired. Timer expiry is immediate after reset.
  - The period timer restarts at every ad_cs falling edge.
- CONV:
  - ad_cs=0, busy=1.
  - Frame counter cnt runs 0..15 (FRAME_LEN=16); cnt=0 is the first cycle with ad_cs low.
  - The ADC drives the bit for slot cnt on the falling edge inside that cycle; the reader samples it on the rising edge that ends the cycle.
  - Slot meaning: cnt=0 is a leading zero; cnt=1..12 carry bits 11..0, MSB first; cnt=13..15 are trailing zeros.
  - On cnt=1..12, each lane shifts its sampled bit into its own 12-bit shift register.
  - On cnt=0, any lane sampling 1 sets frame_err. X/Z on a lane is not checked.
  - On the edge ending cnt=13, the 4 shift registers are copied to vcap/icap/vout/iout and valid=1 for exactly one cycle.
  - valid therefore rises 14 clk edges after the edge that drove ad_cs low.
  - After cnt=15, go to QUIET.
- QUIET:
  - ad_cs=1 for at least QUIET_MIN cycles and until the period timer expires.
  - Then go to CONV if enable=1, else to IDLE.
- enable dropped mid-frame: the current frame completes and delivers valid; no new frame starts.
- Data lanes are ignored outside cnt=0..12, so undriven lanes (X while ad_cs is high) never reach the outputs.
- Word outputs hold their value between valid pulses.
- valid=1 and a new ad_cs falling edge can never coincide, because the period is at least 17.
- Throughput at 48 MHz with the default parameters: 2 MS/s per channel.

Decomposition:
- Shared package ad7352_pkg holds:
  - localparams FRAME_LEN=16, LEAD_SLOT=0, FIRST_BIT_SLOT=1, LAST_BIT_SLOT=12, LOAD_SLOT=13, ADC_BITS=12;
  - the FSM state enum;
  - a packed struct adc_sample_t {vcap, icap, vout, iout}, which the blaster also consumes.
- One sub-module, ad7352_lane: a 12-bit shift register with a shift enable and a leading-zero check, instantiated 4 times.

Test Plan:
- Bench setup: an ADC behavioural model drives lanes on the clk falling edge after detecting ad_cs high-then-low, with 1 leading zero, 12 data bits and trailing zeros. Lanes are X while ad_cs is high.
- Basic frame: vcap=0xA00, icap=0x200, vout=0x0A0, iout=0x200, enable=1 -> valid pulses 14 cycles after ad_cs falls with exactly those words; frame_err=0.
- Pacing: enable held for 5 frames -> ad_cs falls every 24 cycles; ad_cs is low for 16 cycles per frame; 5 valid pulses.
- Bit order/lane map: vcap=0x800, icap=0x001, vout=0xFFF, iout=0x555 -> outputs match exactly; a swapped lane or bit fails the check.
- Enable drop mid-frame at cnt=5 -> the frame completes, valid pulses once, ad_cs stays high afterwards.
- Reset asserted at cnt=8 -> ad_cs=1 and outputs=0 within the same time step, no valid pulse; a clean frame follows after release.
- Framing error: the model drives 1 in the leading slot on vout -> frame_err=1 and stays set through later clean frames until reset.
